hex_display_decoder: RTL
========================

Name: hex_display_decoder

Overview:
- Reconstructs four hex nibbles from the time-multiplexed, active-low 7-segment bus (hex_seg/hex_grid) driven by the lab processor's display driver.
- Sits on the display outputs as a loopback monitor, so a self-test or bench reads displayed Aval/Bval as numbers instead of segment patterns.
- Each digit is captured only after its grid/segment pattern has been stable long enough.
- Pulses a frame strobe once all four digits have been refreshed.

Parameters:
STABLE_CYCLES, 4, consecutive identical samples required before a digit is captured (legal range 1..255)

Ports:
Clk  input  1  system clock
Reset  input  1  asynchronous, active-high reset
hex_seg  input  8  active-low segments: [0]=a,[1]=b,[2]=c,[3]=d,[4]=e,[5]=f,[6]=g,[7]=dp
hex_grid  input  4  active-low digit enables: [0]=rightmost digit (digit 0) … [3]=leftmost (digit 3)
digits  output  16  captured nibbles: digits[4k+3:4k] = digit k
digit_valid  output  4  bit k set once digit k has a legal capture since reset/last error on k
dp_out  output  4  captured decimal points, active-high
frame_done  output  1  one-cycle pulse when all four digits have been captured since the previous pulse
seg_error  output  1  one-cycle pulse: a stable pattern on a selected digit is not a legal hex glyph
grid_error  output  1  one-cycle pulse: more than one hex_grid bit low, stable for STABLE_CYCLES

Behaviour:
- Reset (asynchronous): digits=0, digit_valid=0, dp_out=0, frame_done=0, seg_error=0, grid_error=0, FSM=IDLE, stability counter=0, frame-seen mask=0.
- Inputs are sampled every rising edge into a one-stage register. The previous sample is kept for comparison.
- Glyph table, active-high gfedcba, where hex_seg[6:0] = ~glyph:
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07
  - 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71
  - Any other pattern is illegal.
- FSM states:
  - IDLE: hex_grid==4'hF (blank). Counter held 0. Go to COUNT when any grid bit is low.
  - COUNT: the counter increments while the sampled {hex_grid,hex_seg} equals the previous sample.
    - Any change reloads the counter to 1 and stays in COUNT; a change to an all-blank grid goes to IDLE.
    - When the counter reaches STABLE_CYCLES, go to CAPTURE.
  - CAPTURE (exactly one cycle), one of three cases:
    - Exactly one grid bit low, legal glyph: write the nibble and, if enabled, the dp bit to slot k. Set digit_valid[k] and frame-seen mask bit k.
    - Illegal glyph: seg_error pulse, digit_valid[k] cleared, slot k unchanged.
    - Multiple grid bits low: grid_error pulse, no slot written.
    - In all cases go to HOLD.
  - HOLD: no further captures while the pattern stays identical. Any change goes to COUNT (counter=1), or to IDLE if the new grid is blank.
- Capture latency: an outputs update appears STABLE_CYCLES+2 edges after the pattern first appears at the input (1 sample register + STABLE_CYCLES count + 1 write).
- frame_done:
  - Asserted for one cycle on the edge after the frame-seen mask becomes 4'hF. The mask clears on that same edge.
  - Recapturing an already-seen digit before the frame completes does not advance the frame.
- STABLE_CYCLES=1: capture occurs on the first sample, with no comparison needed.
- The counter saturates and never wraps; HOLD guarantees a single capture per dwell however long the dwell lasts.
- Reset asserted mid-COUNT or mid-CAPTURE aborts the operation immediately. No partial write, no pulse.
- A stable dp-only change (same digit, same glyph, dp toggled) counts as a pattern change and is re-captured.

Optional Feature:
HEX_DECODER_DP_CAPTURE_EN
- Defined: hex_seg[7] is inverted and stored into dp_out[k] on a legal capture, and participates in stability comparison.
- Undefined: dp_out is constant 0, hex_seg[7] is ignored for both stability and capture, and a dp-only toggle causes no re-capture.

Test Plan:
- Reset, then hold grid=4'hE, seg=~8'h06 (digit 1 glyph) for 10 cycles, STABLE_CYCLES=4.
  - digits[3:0]=1 and digit_valid=4'b0001 at cycle 6. Exactly one capture.
- Scan grid E,D,B,7 with glyphs 9, 2, A, F, 5 cycles each.
  - digits=16'hFA29 and digit_valid=4'hF.
  - frame_done is one pulse, on the edge after the digit-3 capture.
- Grid=4'hE, alternate seg between glyphs 3 and 8 every 2 cycles for 20 cycles.
  - No capture, digits unchanged, no pulses.
- Grid=4'hB, seg[6:0]=~7'h00 (blank glyph) stable.
  - One seg_error pulse, digit_valid[2]=0, digits[11:8] unchanged.
- Grid=4'hC (two digits low) stable 6 cycles.
  - One grid_error pulse, no digit written.
- Assert Reset at the counter midpoint of a digit-0 capture of glyph C.
  - All outputs 0 immediately, with no capture after release until a fresh STABLE_CYCLES dwell.
  - With the macro defined, seg[7]=0 on that dwell then gives dp_out[0]=1.

Source files
------------

// File: rtl/hex_display_decoder.sv
// hex_display_decoder
//
// Loopback monitor for a time-multiplexed, active-low 7-segment display bus.
// It turns the displayed glyphs back into four hex nibbles. A digit is
// captured only after its {grid, segment} pattern has been stable for
// STABLE_CYCLES consecutive samples. Each stable dwell produces exactly one
// capture.
//
// Optional build macro: HEX_DECODER_DP_CAPTURE_EN
//   defined   - hex_seg[7] (dp) is part of the stability compare and is stored
//               in dp_out[k] on a legal capture.
//   undefined - dp is ignored completely and dp_out is tied to 0.
//
// Ports
//   Clk          system clock
//   Reset        asynchronous, active-high reset
//   hex_seg      active-low segments [0]=a .. [6]=g, [7]=dp
//   hex_grid     active-low digit enables, [0] = rightmost digit
//   digits       captured nibbles, digits[4k+3:4k] = digit k
//   digit_valid  bit k set after a legal capture of digit k
//   dp_out       captured decimal points, active-high
//   frame_done   one-cycle pulse once all four digits have been captured
//   seg_error    one-cycle pulse, stable pattern is not a hex glyph
//   grid_error   one-cycle pulse, stable grid has more than one digit enabled
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | grid blank, counter held at 0
// COUNT   | counting consecutive identical samples of the pattern
// CAPTURE | single cycle: write the slot or flag an error
// HOLD    | pattern already captured, wait for it to change

module hex_display_decoder #(
   parameter int unsigned STABLE_CYCLES = 4
) (
   input  logic        Clk,
   input  logic        Reset,
   input  logic [7:0]  hex_seg,
   input  logic [3:0]  hex_grid,
   output logic [15:0] digits,
   output logic [3:0]  digit_valid,
   output logic [3:0]  dp_out,
   output logic        frame_done,
   output logic        seg_error,
   output logic        grid_error
);

   localparam logic [7:0] STABLE_TC = 8'(STABLE_CYCLES);

   typedef enum logic [1:0] {IDLE, COUNT, CAPTURE, HOLD} state_t;

   state_t      state;
   logic [3:0]  samp_grid;
   logic [7:0]  samp_seg;
   logic [11:0] samp;
   logic [11:0] pat_q;
   logic [7:0]  cnt;
   logic [3:0]  seen;
   logic [3:0]  dp_q;
   logic [7:0]  seg_in;
   logic        samp_blank;
   logic        samp_same;
   logic        first_done;

   logic [3:0]  grid_lo;
   logic        one_low;
   logic [1:0]  slot;
   logic [4:0]  glyph;

   // With dp capture disabled, the dp line is forced inactive at the input so
   // a dp-only toggle cannot look like a pattern change.
`ifdef HEX_DECODER_DP_CAPTURE_EN
   assign seg_in = hex_seg;
`else
   assign seg_in = {1'b1, hex_seg[6:0]};
`endif

   // The register resets to a blank grid so that reset does not look like
   // all digits being enabled.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         samp_grid <= 4'hF;
         samp_seg  <= 8'hFF;
      end else begin
         samp_grid <= hex_grid;
         samp_seg  <= seg_in;
      end
   end

   assign samp       = {samp_grid, samp_seg};
   assign samp_blank = (samp_grid == 4'hF);
   assign samp_same  = (samp == pat_q);
   // With STABLE_CYCLES=1 the very first sample already completes the dwell.
   assign first_done = (STABLE_TC <= 8'd1);

   function automatic logic [4:0] glyph_decode(input logic [6:0] g);
      case (g)
         7'h3F:   return 5'h10;
         7'h06:   return 5'h11;
         7'h5B:   return 5'h12;
         7'h4F:   return 5'h13;
         7'h66:   return 5'h14;
         7'h6D:   return 5'h15;
         7'h7D:   return 5'h16;
         7'h07:   return 5'h17;
         7'h7F:   return 5'h18;
         7'h6F:   return 5'h19;
         7'h77:   return 5'h1A;
         7'h7C:   return 5'h1B;
         7'h39:   return 5'h1C;
         7'h5E:   return 5'h1D;
         7'h79:   return 5'h1E;
         7'h71:   return 5'h1F;
         default: return 5'h00;
      endcase
   endfunction

   assign grid_lo = ~pat_q[11:8];
   assign one_low = (grid_lo != 4'h0) && ((grid_lo & (grid_lo - 4'h1)) == 4'h0);
   assign glyph   = glyph_decode(~pat_q[6:0]);

   always_comb begin
      slot = 2'd0;
      case (grid_lo)
         4'b0010: slot = 2'd1;
         4'b0100: slot = 2'd2;
         4'b1000: slot = 2'd3;
         default: slot = 2'd0;
      endcase
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state       <= IDLE;
         pat_q       <= 12'hFFF;
         cnt         <= 8'd0;
         seen        <= 4'h0;
         digits      <= 16'h0;
         digit_valid <= 4'h0;
         dp_q        <= 4'h0;
         frame_done  <= 1'b0;
         seg_error   <= 1'b0;
         grid_error  <= 1'b0;
      end else begin
         seg_error  <= 1'b0;
         grid_error <= 1'b0;
         frame_done <= (seen == 4'hF);
         if (seen == 4'hF)
            seen <= 4'h0;

         case (state)
            IDLE: begin
               cnt <= 8'd0;
               if (!samp_blank) begin
                  pat_q <= samp;
                  cnt   <= 8'd1;
                  state <= first_done ? CAPTURE : COUNT;
               end
            end
            COUNT: begin
               if (samp_blank) begin
                  cnt   <= 8'd0;
                  state <= IDLE;
               end else if (!samp_same) begin
                  pat_q <= samp;
                  cnt   <= 8'd1;
                  state <= first_done ? CAPTURE : COUNT;
               end else begin
                  if (cnt != 8'hFF)
                     cnt <= cnt + 8'd1;
                  if (cnt + 8'd1 >= STABLE_TC)
                     state <= CAPTURE;
               end
            end
            CAPTURE: begin
               if (!one_low) begin
                  grid_error <= 1'b1;
               end else if (!glyph[4]) begin
                  seg_error         <= 1'b1;
                  digit_valid[slot] <= 1'b0;
               end else begin
                  digits[slot*4 +: 4] <= glyph[3:0];
                  dp_q[slot]          <= ~pat_q[7];
                  digit_valid[slot]   <= 1'b1;
                  seen                <= seen | (4'h1 << slot);
               end
               state <= HOLD;
            end
            HOLD: begin
               if (samp_blank) begin
                  cnt   <= 8'd0;
                  state <= IDLE;
               end else if (!samp_same) begin
                  pat_q <= samp;
                  cnt   <= 8'd1;
                  state <= first_done ? CAPTURE : COUNT;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef HEX_DECODER_DP_CAPTURE_EN
   assign dp_out = dp_q;
`else
   assign dp_out = 4'h0;
`endif

endmodule
